// File: rtl/time_keeper_if.sv
// Bundles the tick, set buttons and time outputs of the time keeper.
// The master side drives ticks/buttons; the slave side is the clock itself.
interface time_keeper_if;
  logic       hit;
  logic       btn_min;
  logic       btn_hour;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       set_active;
  logic       day_wrap;

  modport master (
    output hit, btn_min, btn_hour,
    input  minutes, hours, set_active, day_wrap
  );

  modport slave (
    input  hit, btn_min, btn_hour,
    output minutes, hours, set_active, day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// Minute/hour time-of-day counter with press-and-hold setting buttons.
// Each button runs its own IDLE/DELAY/REPEAT FSM producing increment pulses.
module time_keeper #(
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
  input  logic          ck,
  input  logic          reset,
  time_keeper_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_DELAY - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_PERIOD - 1);

  logic [1:0]       btn;
  logic [1:0][1:0]  state_q, state_d;
  logic [1:0][31:0] timer_q, timer_d;
  logic [1:0]       inc;

  logic [5:0] minutes_q, minutes_d;
  logic [4:0] hours_q, hours_d;
  logic       set_active_q, set_active_d;
  logic       day_wrap_q, day_wrap_d;

  logic       hit_ok;
  logic [5:0] minutes_next;
  logic [4:0] hours_next;

  // index 0 is the minute button, index 1 the hour button
  assign btn = {bus.btn_hour, bus.btn_min};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    inc     = '0;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (btn[i]) begin
            inc[i]     = 1'b1;
            timer_d[i] = '0;
            state_d[i] = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!btn[i]) begin
            timer_d[i] = '0;
            state_d[i] = ST_IDLE;
          end else if (timer_q[i] == HOLD_LAST) begin
            inc[i]     = 1'b1;
            timer_d[i] = '0;
            state_d[i] = ST_REPEAT;
          end else begin
            timer_d[i] = timer_q[i] + 32'd1;
          end
        end
        ST_REPEAT: begin
          if (!btn[i]) begin
            timer_d[i] = '0;
            state_d[i] = ST_IDLE;
          end else if (timer_q[i] == REPEAT_LAST) begin
            inc[i]     = 1'b1;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + 32'd1;
          end
        end
        default: begin
          timer_d[i] = '0;
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Ticks are dropped while any button is being serviced, including the press cycle
  always_comb begin
    minutes_next = (minutes_q >= 6'd59) ? 6'd0 : minutes_q + 6'd1;
    hours_next   = (hours_q >= 5'd23) ? 5'd0 : hours_q + 5'd1;
    set_active_d = (state_d[0] != ST_IDLE) || (state_d[1] != ST_IDLE);
    hit_ok       = bus.hit && !set_active_q && !set_active_d;

    minutes_d  = minutes_q;
    hours_d    = hours_q;
    day_wrap_d = 1'b0;
    if (hit_ok) begin
      minutes_d = minutes_next;
      if (minutes_q >= 6'd59) begin
        hours_d    = hours_next;
        day_wrap_d = (hours_q >= 5'd23);
      end
    end else begin
      if (inc[0]) minutes_d = minutes_next;
      if (inc[1]) hours_d   = hours_next;
    end
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      state_q      <= {ST_IDLE, ST_IDLE};
      timer_q      <= '0;
      minutes_q    <= '0;
      hours_q      <= '0;
      set_active_q <= 1'b0;
      day_wrap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      minutes_q    <= minutes_d;
      hours_q      <= hours_d;
      set_active_q <= set_active_d;
      day_wrap_q   <= day_wrap_d;
    end
  end

  assign bus.minutes    = minutes_q;
  assign bus.hours      = hours_q;
  assign bus.set_active = set_active_q;
  assign bus.day_wrap   = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with HOLD_DELAY=5, REPEAT_PERIOD=3.
// Inputs change and outputs are sampled on the falling edge of ck.
module tb_time_keeper;

  logic ck;
  logic reset;
  int   check_count;
  int   error_count;
  int   hours_exp;

  time_keeper_if bus();

  time_keeper #(
    .HOLD_DELAY    (5),
    .REPEAT_PERIOD (3)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // drive one cycle of inputs and return at the following falling edge
  task automatic applyStimulus(input logic h, input logic bm, input logic bh);
    bus.hit      = h;
    bus.btn_min  = bm;
    bus.btn_hour = bh;
    @(negedge ck);
  endtask

  task automatic pressButton(input logic hour_btn, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, !hour_btn, hour_btn);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    reset = 1'b0;
    bus.hit = 1'b0;
    bus.btn_min = 1'b0;
    bus.btn_hour = 1'b0;
    @(negedge ck);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_minutes", bus.minutes, 0);
    checkOutput("rst_hours", bus.hours, 0);
    checkOutput("rst_set_active", bus.set_active, 0);
    checkOutput("rst_day_wrap", bus.day_wrap, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // short press: one increment, set_active high for three cycles
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("short_min_latency", bus.minutes, 1);
    checkOutput("short_active_c0", bus.set_active, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("short_active_c1", bus.set_active, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("short_active_c2", bus.set_active, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("short_active_off", bus.set_active, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("short_min_final", bus.minutes, 1);

    // auto-repeat: increments land on cycles 0, 5, 8 and 11
    hours_exp = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 0 || k == 5 || k == 8 || k == 11) hours_exp++;
      checkOutput($sformatf("repeat_hours_c%0d", k), bus.hours, hours_exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("repeat_hours_final", bus.hours, 4);
    checkOutput("repeat_active_off", bus.set_active, 0);
    checkOutput("repeat_minutes_kept", bus.minutes, 1);

    // minute wrap without carry, from 07:59
    pressButton(1'b1, 3);
    pressButton(1'b0, 58);
    checkOutput("preload_minutes_59", bus.minutes, 59);
    checkOutput("preload_hours_7", bus.hours, 7);
    pressButton(1'b0, 1);
    checkOutput("minwrap_minutes", bus.minutes, 0);
    checkOutput("minwrap_hours", bus.hours, 7);

    // both buttons in the same cycle
    pressButton(1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("both_minutes", bus.minutes, 1);
    checkOutput("both_hours", bus.hours, 8);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // rollover from 23:58 with two ticks
    pressButton(1'b1, 15);
    pressButton(1'b0, 57);
    checkOutput("preload_minutes_58", bus.minutes, 58);
    checkOutput("preload_hours_23", bus.hours, 23);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hit1_minutes", bus.minutes, 59);
    checkOutput("hit1_day_wrap", bus.day_wrap, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hit2_minutes", bus.minutes, 0);
    checkOutput("hit2_hours", bus.hours, 0);
    checkOutput("hit2_day_wrap", bus.day_wrap, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("day_wrap_pulse_end", bus.day_wrap, 0);

    // tick while a button is held is dropped
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("set_hit_press", bus.minutes, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("set_hit_ignored", bus.minutes, 1);
    checkOutput("set_hit_day_wrap", bus.day_wrap, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_hit_counts", bus.minutes, 2);

    // reset while the minute button is auto-repeating
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hold_minutes", bus.minutes, 4);
    checkOutput("hold_set_active", bus.set_active, 1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midrst_minutes", bus.minutes, 0);
    checkOutput("midrst_hours", bus.hours, 0);
    checkOutput("midrst_set_active", bus.set_active, 0);
    checkOutput("midrst_day_wrap", bus.day_wrap, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("postrst_minutes", bus.minutes, 1);
    checkOutput("postrst_set_active", bus.set_active, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("postrst_release", bus.minutes, 1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
